// File: rtl/wire_event_monitor_if.sv
// ---------------------------------------------------------------------------
// wire_event_monitor_if
// One-entry event record handshake between the wire event monitor (master)
// and its downstream consumer (slave).
//   evt_valid   : a record is available (master -> slave)
//   evt_is_rise : record type, 1 = rise, 0 = fall (master -> slave)
//   evt_ready   : consumer accepts the record this cycle (slave -> master)
// ---------------------------------------------------------------------------
interface wire_event_monitor_if;
    logic evt_valid;
    logic evt_is_rise;
    logic evt_ready;

    modport master (
        output evt_valid,
        output evt_is_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_is_rise,
        output evt_ready
    );
endinterface

// File: rtl/wire_event_monitor.sv
// ---------------------------------------------------------------------------
// wire_event_monitor
// Watches the complementary pair out/out_n of an upstream AND-OR stage.
// Both wires are synchronized, the true wire is debounced by a run-length
// filter FSM, and qualified edges are reported as pulses, as a saturating
// rise count and as one-entry valid/ready event records.
//
// Ports:
//   clk, reset   : single clock, asynchronous active-high reset
//   in, in_n     : true / complement wire from the upstream stage
//   clear        : synchronous clear of rise_cnt, err, ovf and the record
//   level        : filtered level (1 in HIGH and CHK_LOW)
//   rise, fall   : one-cycle pulses on qualified transitions
//   rise_cnt     : saturating count of qualified rises
//   err          : sticky, s == s_n seen on two consecutive cycles
//   ovf          : sticky, an event was dropped because the record was full
//   evt          : event record handshake (master side)
//
// Note: the synchronizers reset to 0 on both wires, so the pair looks
// non-complementary while they fill after reset and err will normally be
// set then; consumers are expected to pulse clear once the inputs settle.
// ---------------------------------------------------------------------------
module wire_event_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 in_n,
    input  logic                 clear,
    output logic                 level,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_W-1:0]     rise_cnt,
    output logic                 err,
    output logic                 ovf,
    wire_event_monitor_if.master evt
);

    localparam int RUN_W = $clog2(FILTER_LEN + 1);
    // The run counter holds the number of agreeing samples already taken;
    // the sample that would bring it to FILTER_LEN commits the transition.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q,   sync_d;
    logic [SYNC_STAGES-1:0] sync_n_q, sync_n_d;
    state_t                 state_q,  state_d;
    logic [RUN_W-1:0]       run_q,    run_d;
    logic                   level_q,  level_d;
    logic                   rise_q,   rise_d;
    logic                   fall_q,   fall_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   eq_prev_q, eq_prev_d;
    logic                   err_q,    err_d;
    logic                   ovf_q,    ovf_d;
    logic                   evt_valid_q,   evt_valid_d;
    logic                   evt_is_rise_q, evt_is_rise_d;

    logic s;
    logic s_n;
    logic eq_s;
    logic new_evt_s;
    logic slot_free_s;

    assign s           = sync_q[SYNC_STAGES-1];
    assign s_n         = sync_n_q[SYNC_STAGES-1];
    assign eq_s        = (s == s_n);
    assign new_evt_s   = rise_d | fall_d;
    // A full record frees its slot on the same edge it is accepted.
    assign slot_free_s = ~evt_valid_q | evt.evt_ready;

    // Synchronizer shift chains for both wires.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], in};
        sync_n_d = {sync_n_q[SYNC_STAGES-2:0], in_n};
    end

    // Debounce FSM: a level change needs FILTER_LEN consecutive opposite samples.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = ST_CHK_HIGH;
                    run_d   = RUN_W'(1);
                end else begin
                    run_d   = RUN_W'(0);
                end
            end
            ST_CHK_HIGH: begin
                if (s) begin
                    if (run_q == RUN_LAST) begin
                        state_d = ST_HIGH;
                        run_d   = RUN_W'(0);
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        run_d   = run_q + RUN_W'(1);
                    end
                end else begin
                    state_d = ST_LOW;
                    run_d   = RUN_W'(0);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = ST_CHK_LOW;
                    run_d   = RUN_W'(1);
                end else begin
                    run_d   = RUN_W'(0);
                end
            end
            ST_CHK_LOW: begin
                if (!s) begin
                    if (run_q == RUN_LAST) begin
                        state_d = ST_LOW;
                        run_d   = RUN_W'(0);
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        run_d   = run_q + RUN_W'(1);
                    end
                end else begin
                    state_d = ST_HIGH;
                    run_d   = RUN_W'(0);
                end
            end
            default: begin
                state_d = ST_LOW;
                run_d   = RUN_W'(0);
                level_d = 1'b0;
            end
        endcase
    end

    // Complementarity check, rise counter and one-entry event record; clear wins.
    always_comb begin
        eq_prev_d     = eq_s;
        err_d         = err_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        evt_valid_d   = evt_valid_q;
        evt_is_rise_d = evt_is_rise_q;
        if (clear) begin
            err_d       = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
            ovf_d       = 1'b0;
            evt_valid_d = 1'b0;
        end else begin
            if (eq_s && eq_prev_q) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (rise_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (new_evt_s) begin
                if (slot_free_s) begin
                    evt_valid_d   = 1'b1;
                    evt_is_rise_d = rise_d;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (evt_valid_q && evt.evt_ready) begin
                evt_valid_d = 1'b0;
            end else begin
                evt_valid_d = evt_valid_q;
            end
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= {SYNC_STAGES{1'b0}};
            sync_n_q      <= {SYNC_STAGES{1'b0}};
            state_q       <= ST_LOW;
            run_q         <= RUN_W'(0);
            level_q       <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
            eq_prev_q     <= 1'b0;
            err_q         <= 1'b0;
            ovf_q         <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_is_rise_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            sync_n_q      <= sync_n_d;
            state_q       <= state_d;
            run_q         <= run_d;
            level_q       <= level_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            cnt_q         <= cnt_d;
            eq_prev_q     <= eq_prev_d;
            err_q         <= err_d;
            ovf_q         <= ovf_d;
            evt_valid_q   <= evt_valid_d;
            evt_is_rise_q <= evt_is_rise_d;
        end
    end

    assign level           = level_q;
    assign rise            = rise_q;
    assign fall            = fall_q;
    assign rise_cnt        = cnt_q;
    assign err             = err_q;
    assign ovf             = ovf_q;
    assign evt.evt_valid   = evt_valid_q;
    assign evt.evt_is_rise = evt_is_rise_q;

endmodule

// File: tb/tb_wire_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_wire_event_monitor
// Directed bench with a scoreboard. Stimulus pushes the expected edge pulses
// (type, cycle, rise count) and expected event records into queues; a
// monitor sampling one time unit before each rising edge pops and compares
// whenever the DUT shows a rise/fall pulse or a record transfer.
// Built with CNT_W = 2 so rise count saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_wire_event_monitor;

    typedef struct {
        logic       is_rise;
        int         cyc;
        logic [1:0] cnt;
    } pulse_t;

    logic       clk;
    logic       reset;
    logic       din;
    logic       din_n;
    logic       clear;
    logic       level;
    logic       rise;
    logic       fall;
    logic [1:0] rise_cnt;
    logic       err;
    logic       ovf;

    wire_event_monitor_if evt_if ();

    wire_event_monitor #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (4),
        .CNT_W       (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .in_n     (din_n),
        .clear    (clear),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .rise_cnt (rise_cnt),
        .err      (err),
        .ovf      (ovf),
        .evt      (evt_if)
    );

    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    pulse_t pulse_q[$];
    logic   evt_q[$];
    pulse_t mon_p;
    logic   mon_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Step to 1 time unit after the n-th next falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input logic r, input int dly, input logic [1:0] c);
        pulse_t p;
        p.is_rise = r;
        p.cyc     = cyc + dly;
        p.cnt     = c;
        pulse_q.push_back(p);
    endtask

    // Monitor: samples just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            if (rise || fall) begin
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, rise, fall}, 32'd0);
                end else begin
                    mon_p = pulse_q.pop_front();
                    chk("pulse_kind",  {30'd0, rise, fall}, mon_p.is_rise ? 32'd2 : 32'd1);
                    chk("pulse_cycle", cyc, mon_p.cyc);
                    chk("pulse_level", {31'd0, level}, {31'd0, mon_p.is_rise});
                    chk("pulse_cnt",   {30'd0, rise_cnt}, {30'd0, mon_p.cnt});
                end
            end
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                if (evt_q.size() == 0) begin
                    chk("unexpected_evt_xfer", {31'd0, evt_if.evt_valid}, 32'd0);
                end else begin
                    mon_r = evt_q.pop_front();
                    chk("evt_is_rise", {31'd0, evt_if.evt_is_rise}, {31'd0, mon_r});
                end
            end
        end
    end

    initial begin
        din = 1'b0; din_n = 1'b1; clear = 1'b0; evt_if.evt_ready = 1'b1; reset = 1'b1;
        tick(2);
        chk("rst_outputs", {level, rise, fall, rise_cnt, err, ovf, evt_if.evt_valid, evt_if.evt_is_rise}, 32'd0);
        reset = 1'b0;
        // Synchronizers fill with 0/0 after reset; wipe the startup err.
        tick(4);
        clear = 1'b1; tick(1); clear = 1'b0; tick(1);
        chk("startup_err_cleared", {31'd0, err}, 32'd0);

        // Basic rise, E0+5 latency.
        din = 1'b1; din_n = 1'b0;
        expect_pulse(1'b1, 6, 2'd1); evt_q.push_back(1'b1);
        tick(6);
        chk("basic_level",     {31'd0, level}, 32'd1);
        chk("basic_evt_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        chk("basic_evt_rise",  {31'd0, evt_if.evt_is_rise}, 32'd1);
        chk("basic_cnt",       {30'd0, rise_cnt}, 32'd1);
        tick(1);
        chk("basic_rise_1cyc", {31'd0, rise}, 32'd0);
        chk("basic_drained",   {31'd0, evt_if.evt_valid}, 32'd0);

        // Basic fall.
        din = 1'b0; din_n = 1'b1;
        expect_pulse(1'b0, 6, 2'd1); evt_q.push_back(1'b0);
        tick(6);
        chk("fall_level", {31'd0, level}, 32'd0);
        tick(3);

        // 3-cycle glitch is rejected.
        din = 1'b1; din_n = 1'b0;
        tick(3);
        din = 1'b0; din_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch3_level", {31'd0, level}, 32'd0);
        end
        chk("glitch3_cnt", {30'd0, rise_cnt}, 32'd1);

        // 4-cycle pulse: rise, then fall 4 cycles later.
        din = 1'b1; din_n = 1'b0;
        expect_pulse(1'b1, 6, 2'd2); evt_q.push_back(1'b1);
        tick(4);
        din = 1'b0; din_n = 1'b1;
        expect_pulse(1'b0, 6, 2'd2); evt_q.push_back(1'b0);
        tick(10);

        // Overflow: record held, second event dropped.
        evt_if.evt_ready = 1'b0;
        din = 1'b1; din_n = 1'b0;
        expect_pulse(1'b1, 6, 2'd3); evt_q.push_back(1'b1);
        tick(6);
        din = 1'b0; din_n = 1'b1;
        expect_pulse(1'b0, 6, 2'd3);
        tick(7);
        chk("ovf_set",        {31'd0, ovf}, 32'd1);
        chk("ovf_held_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        chk("ovf_held_rise",  {31'd0, evt_if.evt_is_rise}, 32'd1);
        evt_if.evt_ready = 1'b1;
        tick(1);
        chk("ovf_drained", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("ovf_sticky",  {31'd0, ovf}, 32'd1);

        // Saturation: further rises hold the count at 3.
        for (int i = 0; i < 2; i++) begin
            din = 1'b1; din_n = 1'b0;
            expect_pulse(1'b1, 6, 2'd3); evt_q.push_back(1'b1);
            tick(6);
            din = 1'b0; din_n = 1'b1;
            expect_pulse(1'b0, 6, 2'd3); evt_q.push_back(1'b0);
            tick(8);
            chk("sat_cnt", {30'd0, rise_cnt}, 32'd3);
        end

        // Complementarity: one equal sample is tolerated, two set err.
        din_n = 1'b0; tick(1); din_n = 1'b1; tick(5);
        chk("cmp_single_ok", {31'd0, err}, 32'd0);
        din_n = 1'b0; tick(2); din_n = 1'b1; tick(4);
        chk("cmp_err_set", {31'd0, err}, 32'd1);
        tick(3);
        chk("cmp_err_sticky", {31'd0, err}, 32'd1);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("clr_err",   {31'd0, err}, 32'd0);
        chk("clr_cnt",   {30'd0, rise_cnt}, 32'd0);
        chk("clr_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("clr_ovf",   {31'd0, ovf}, 32'd0);

        // Clear coincident with the rise edge: pulse stays, count/record do not.
        din = 1'b1; din_n = 1'b0;
        expect_pulse(1'b1, 6, 2'd0);
        tick(5);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("coclr_valid", {31'd0, evt_if.evt_valid}, 32'd0);
        chk("coclr_cnt",   {30'd0, rise_cnt}, 32'd0);
        tick(2);
        din = 1'b0; din_n = 1'b1;
        expect_pulse(1'b0, 6, 2'd0); evt_q.push_back(1'b0);
        tick(8);

        // Back-to-back drain and load on the same edge: no drop.
        evt_if.evt_ready = 1'b0;
        din = 1'b1; din_n = 1'b0;
        expect_pulse(1'b1, 6, 2'd1); evt_q.push_back(1'b1);
        tick(6);
        din = 1'b0; din_n = 1'b1;
        expect_pulse(1'b0, 6, 2'd1); evt_q.push_back(1'b0);
        tick(5);
        evt_if.evt_ready = 1'b1;
        tick(1);
        chk("b2b_valid", {31'd0, evt_if.evt_valid}, 32'd1);
        chk("b2b_kind",  {31'd0, evt_if.evt_is_rise}, 32'd0);
        chk("b2b_no_ovf", {31'd0, ovf}, 32'd0);
        tick(2);
        chk("b2b_drained", {31'd0, evt_if.evt_valid}, 32'd0);

        // Mid-run reset while in CHK_HIGH, in held high through release.
        din = 1'b1; din_n = 1'b0;
        tick(4);
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {level, rise, fall, rise_cnt, err, ovf, evt_if.evt_valid, evt_if.evt_is_rise}, 32'd0);
        tick(2);
        reset = 1'b0;
        expect_pulse(1'b1, 6, 2'd1); evt_q.push_back(1'b1);
        tick(6);
        chk("midrst_level", {31'd0, level}, 32'd1);
        chk("midrst_cnt",   {30'd0, rise_cnt}, 32'd1);
        tick(3);

        chk("pulse_q_drained", pulse_q.size(), 32'd0);
        chk("evt_q_drained",   evt_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
